mc_control: RTL

Multi-cycle control unit that sequences the shared MIPS datapath (PC, one unified memory port, register file, ALU, EXT) over several clocks per instruction, replacing the single-cycle combinational decoder. It decodes `Op`/`Funct` from the instruction register and drives Moore control outputs from a state register. It stalls on the memory ready handshake and signals instruction retirement and illegal opcodes.

---
 rtl/mc_pkg.sv | 60 ++++++
 rtl/mc_decode.sv | 52 +++++
 rtl/mc_control.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// constants, ALU operation codes and datapath mux select values.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_SH  = 4'd3,
    EXEC_I   = 4'd4,
    WB_ALU   = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WR   = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JREG     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [5:0] {
    ALU_ADD = 6'd0,
    ALU_SUB = 6'd1,
    ALU_AND = 6'd2,
    ALU_OR  = 6'd3,
    ALU_SLT = 6'd4,
    ALU_SLL = 6'd5,
    ALU_SRL = 6'd6,
    ALU_LUI = 6'd7
  } aluop_e;

  typedef enum logic [1:0] {PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_RS} pcsrc_e;
  typedef enum logic [1:0] {REGDST_RD, REGDST_RT, REGDST_RA} regdst_e;
  typedef enum logic [1:0] {MTR_ALUOUT, MTR_MDR, MTR_PC} memtoreg_e;
  typedef enum logic [1:0] {SRCA_PC, SRCA_RS, SRCA_SHAMT} srca_e;
  typedef enum logic [1:0] {SRCB_RT, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SL2} srcb_e;
  typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_LUI} extop_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction lookup: maps Op/Funct to the state that follows DECODE,
// the ALU operation used during execute, and the immediate extension mode.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output state_e     execState,
  output aluop_e     aluOp,
  output extop_e     extOp,
  output logic       illegal
);

  always_comb begin
    execState = FETCH;
    aluOp     = ALU_ADD;
    extOp     = EXT_ZERO;
    illegal   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin execState = EXEC_R;  aluOp = ALU_ADD; end
          FN_SUB:  begin execState = EXEC_R;  aluOp = ALU_SUB; end
          FN_AND:  begin execState = EXEC_R;  aluOp = ALU_AND; end
          FN_OR:   begin execState = EXEC_R;  aluOp = ALU_OR;  end
          FN_SLT:  begin execState = EXEC_R;  aluOp = ALU_SLT; end
          FN_SLL:  begin execState = EXEC_SH; aluOp = ALU_SLL; end
          FN_SRL:  begin execState = EXEC_SH; aluOp = ALU_SRL; end
          FN_JR:   execState = JREG;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin execState = EXEC_I; aluOp = ALU_ADD; extOp = EXT_SIGN; end
      OP_ANDI: begin execState = EXEC_I; aluOp = ALU_AND; extOp = EXT_ZERO; end
      OP_ORI:  begin execState = EXEC_I; aluOp = ALU_OR;  extOp = EXT_ZERO; end
      OP_LUI:  begin execState = EXEC_I; aluOp = ALU_LUI; extOp = EXT_LUI;  end
      OP_LW, OP_SW: begin
        execState = MEM_ADDR;
        aluOp     = ALU_ADD;
        extOp     = EXT_SIGN;
      end
      OP_BEQ, OP_BNE: begin
        execState = BRANCH;
        aluOp     = ALU_SUB;
        extOp     = EXT_SIGN;
      end
      OP_J, OP_JAL: execState = JUMP;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the shared MIPS datapath. Moore outputs from the state
// register; only the memory handshake states qualify their effects with MIO_ready.
module mc_control
  import mc_pkg::*;
#(
  parameter int ALUOP_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               MIO_ready,
  output logic               CPU_MIO,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Reverse,
  output logic [1:0]         PCSource,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         EXTOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               instr_done,
  output logic               illegal,
  output logic [3:0]         state_o
);

  state_e stateReg;
  state_e stateNext;
  state_e decExecState;
  aluop_e decAluOp;
  extop_e decExtOp;
  logic   decIllegal;

  mc_decode uDecode (
    .op        (Op),
    .funct     (Funct),
    .execState (decExecState),
    .aluOp     (decAluOp),
    .extOp     (decExtOp),
    .illegal   (decIllegal)
  );

  always_ff @(posedge clk) begin
    if (!reset) stateReg <= FETCH;
    else        stateReg <= stateNext;
  end

  assign state_o = stateReg;

  // Outputs are forced to zero while reset is held, regardless of the current state.
  always_comb begin
    stateNext   = stateReg;
    CPU_MIO     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Reverse     = 1'b0;
    PCSource    = PCSRC_ALU;
    RegDst      = REGDST_RD;
    MemtoReg    = MTR_ALUOUT;
    RegWrite    = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RT;
    EXTOp       = EXT_ZERO;
    ALUOp       = '0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    if (reset) begin
      case (stateReg)
        FETCH: begin
          CPU_MIO = 1'b1;
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          ALUOp   = ALUOP_W'(ALU_ADD);
          if (MIO_ready) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            stateNext = DECODE;
          end
        end
        DECODE: begin
          ALUSrcB = SRCB_IMM_SL2;
          EXTOp   = EXT_SIGN;
          ALUOp   = ALUOP_W'(ALU_ADD);
          illegal = decIllegal;
          stateNext = decExecState;
        end
        EXEC_R: begin
          ALUSrcA   = SRCA_RS;
          ALUOp     = ALUOP_W'(decAluOp);
          stateNext = WB_ALU;
        end
        EXEC_SH: begin
          ALUSrcA   = SRCA_SHAMT;
          ALUOp     = ALUOP_W'(decAluOp);
          stateNext = WB_ALU;
        end
        EXEC_I: begin
          ALUSrcA   = SRCA_RS;
          ALUSrcB   = SRCB_IMM;
          EXTOp     = decExtOp;
          ALUOp     = ALUOP_W'(decAluOp);
          stateNext = WB_ALU;
        end
        WB_ALU: begin
          RegWrite   = 1'b1;
          RegDst     = (Op == OP_RTYPE) ? REGDST_RD : REGDST_RT;
          instr_done = 1'b1;
          stateNext  = FETCH;
        end
        MEM_ADDR: begin
          ALUSrcA   = SRCA_RS;
          ALUSrcB   = SRCB_IMM;
          EXTOp     = EXT_SIGN;
          ALUOp     = ALUOP_W'(ALU_ADD);
          stateNext = (Op == OP_LW) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          CPU_MIO = 1'b1;
          IorD    = 1'b1;
          MemRead = 1'b1;
          if (MIO_ready) stateNext = WB_MEM;
        end
        MEM_WR: begin
          // Strobe stays up through stalls; the store retires on the ready cycle.
          CPU_MIO  = 1'b1;
          IorD     = 1'b1;
          MemWrite = 1'b1;
          if (MIO_ready) begin
            instr_done = 1'b1;
            stateNext  = FETCH;
          end
        end
        WB_MEM: begin
          RegWrite   = 1'b1;
          RegDst     = REGDST_RT;
          MemtoReg   = MTR_MDR;
          instr_done = 1'b1;
          stateNext  = FETCH;
        end
        BRANCH: begin
          ALUSrcA     = SRCA_RS;
          ALUOp       = ALUOP_W'(ALU_SUB);
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          Reverse     = (Op == OP_BNE);
          instr_done  = 1'b1;
          stateNext   = FETCH;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
          if (Op == OP_JAL) begin
            RegWrite = 1'b1;
            RegDst   = REGDST_RA;
            MemtoReg = MTR_PC;
          end
          instr_done = 1'b1;
          stateNext  = FETCH;
        end
        JREG: begin
          PCWrite    = 1'b1;
          PCSource   = PCSRC_RS;
          instr_done = 1'b1;
          stateNext  = FETCH;
        end
        default: stateNext = FETCH;
      endcase
    end
  end

endmodule
